// File: rtl/fsm_pattern_checker.sv
// Purpose: receive-side frame checker for the repeating serial pattern 0,1,1,1 (hunt, sync, lock, flywheel).
// Latency: every output is registered and reflects a qualified sample one cycle after its sampling edge.
// Backpressure: none; en=0 cycles are skipped with all state held. Optional err_clr port: FSM_PATTERN_CHECKER_ERR_CLR_EN.
module fsm_pattern_checker #(
   parameter int LOCK_FRAMES   = 2,
   parameter int UNLOCK_FRAMES = 3,
   parameter int ERR_CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 x,
   input  logic                 en,
`ifdef FSM_PATTERN_CHECKER_ERR_CLR_EN
   input  logic                 err_clr,
`endif
   output logic                 locked,
   output logic [1:0]           phase,
   output logic                 bit_err,
   output logic                 frame_ok,
   output logic [ERR_CNT_W-1:0] err_count
);

   typedef enum logic [1:0] {
      ST_HUNT = 2'd0,
      ST_SYNC = 2'd1,
      ST_LOCK = 2'd2
   } state_t;

   localparam logic [3:0] LOCK_N   = 4'(LOCK_FRAMES);
   localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_FRAMES);

   state_t               state_q, state_d;
   logic [1:0]           phase_q, phase_d;
   logic [3:0]           good_q, good_d;
   logic [3:0]           bad_q, bad_d;
   logic                 frame_err_q, frame_err_d;
   logic                 locked_q, locked_d;
   logic                 bit_err_q, bit_err_d;
   logic                 frame_ok_q, frame_ok_d;
   logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

   logic                 exp_bit;
   logic                 mismatch;
   logic                 lock_mis;
   logic                 frame_bad;
   logic [3:0]           good_inc;
   logic [3:0]           bad_inc;
   logic                 err_clr_i;

`ifdef FSM_PATTERN_CHECKER_ERR_CLR_EN
   assign err_clr_i = err_clr;
`else
   assign err_clr_i = 1'b0;
`endif

   // Next-state, counters and output pulses; a held sample (en=0) only drops the pulses.
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      good_d      = good_q;
      bad_d       = bad_q;
      frame_err_d = frame_err_q;
      err_count_d = err_count_q;
      bit_err_d   = 1'b0;
      frame_ok_d  = 1'b0;
      lock_mis    = 1'b0;
      frame_bad   = 1'b0;
      exp_bit     = (phase_q != 2'd0);
      mismatch    = x ^ exp_bit;
      good_inc    = good_q + 4'd1;
      bad_inc     = bad_q + 4'd1;

      if (en) begin
         case (state_q)
            ST_HUNT: begin
               // Only the lone 0 bit can start a frame; 1s are skipped.
               if (!x) begin
                  state_d = ST_SYNC;
                  phase_d = 2'd1;
                  good_d  = 4'd0;
               end
            end
            ST_SYNC: begin
               if (mismatch) begin
                  if (!x) begin
                     // An unexpected 0 is taken as the true frame start.
                     phase_d = 2'd1;
                     good_d  = 4'd0;
                  end else begin
                     state_d = ST_HUNT;
                     phase_d = 2'd0;
                  end
               end else begin
                  phase_d = phase_q + 2'd1;
                  if (phase_q == 2'd3) begin
                     frame_ok_d = 1'b1;
                     good_d     = good_inc;
                     if (good_inc == LOCK_N) begin
                        state_d     = ST_LOCK;
                        bad_d       = 4'd0;
                        frame_err_d = 1'b0;
                     end
                  end
               end
            end
            ST_LOCK: begin
               // Flywheel: phase never realigns while locked.
               phase_d = phase_q + 2'd1;
               if (mismatch) begin
                  lock_mis    = 1'b1;
                  bit_err_d   = 1'b1;
                  frame_err_d = 1'b1;
                  if (err_count_q != {ERR_CNT_W{1'b1}}) begin
                     err_count_d = err_count_q + ERR_CNT_W'(1);
                  end
               end
               if (phase_q == 2'd3) begin
                  frame_bad   = frame_err_q | mismatch;
                  frame_err_d = 1'b0;
                  if (frame_bad) begin
                     bad_d = bad_inc;
                     if (bad_inc == UNLOCK_N) begin
                        state_d = ST_HUNT;
                        phase_d = 2'd0;
                        bad_d   = 4'd0;
                     end
                  end else begin
                     frame_ok_d = 1'b1;
                     bad_d      = 4'd0;
                  end
               end
            end
            default: begin
               state_d = ST_HUNT;
               phase_d = 2'd0;
            end
         endcase
      end

      // err_clr wins over the increment, but a coincident mismatch still counts once.
      if (err_clr_i) begin
         err_count_d = lock_mis ? ERR_CNT_W'(1) : '0;
      end

      locked_d = (state_d == ST_LOCK);
   end

   // State and output registers with synchronous active-low clear.
   always_ff @(posedge clk) begin
      if (!clr) begin
         state_q     <= ST_HUNT;
         phase_q     <= 2'd0;
         good_q      <= 4'd0;
         bad_q       <= 4'd0;
         frame_err_q <= 1'b0;
         locked_q    <= 1'b0;
         bit_err_q   <= 1'b0;
         frame_ok_q  <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         good_q      <= good_d;
         bad_q       <= bad_d;
         frame_err_q <= frame_err_d;
         locked_q    <= locked_d;
         bit_err_q   <= bit_err_d;
         frame_ok_q  <= frame_ok_d;
         err_count_q <= err_count_d;
      end
   end

   assign locked    = locked_q;
   assign phase     = phase_q;
   assign bit_err   = bit_err_q;
   assign frame_ok  = frame_ok_q;
   assign err_count = err_count_q;

endmodule
